// File: rtl/add_mp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_mp_ctrl
// Purpose  : Word-serial multi-precision add/sub sequencer around a shared
//            W-bit adder (1..NW words, LSW first, carry rippled through).
// Revision : 1.0
// ============================================================================
module add_mp_ctrl #(
    parameter int W  = 64,
    parameter int NW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sub,
    input  logic [1:0]      len,
    input  logic [NW*W-1:0] op_a,
    input  logic [NW*W-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [NW*W-1:0] result,
    output logic            carry_out,
    output logic [W-1:0]    add_a,
    output logic [W-1:0]    add_b,
    output logic            add_cin,
    input  logic [W-1:0]    add_s,
    input  logic            add_cout
);

    localparam int LW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q   [NW];
    logic [W-1:0]   a_d   [NW];
    logic [W-1:0]   b_q   [NW];
    logic [W-1:0]   b_d   [NW];
    logic [W-1:0]   res_q [NW];
    logic [W-1:0]   res_d [NW];
    logic           sub_q, sub_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sub_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        len_d   = len_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    sub_d   = sub;
                    len_d   = len;
                    idx_d   = '0;
                    // Subtraction is A + ~B + 1, so the initial carry is sub.
                    carry_d = sub;
                    for (int i = 0; i < NW; i++) begin
                        a_d[i]   = op_a[i*W +: W];
                        b_d[i]   = op_b[i*W +: W];
                        res_d[i] = '0;
                    end
                end
            end
            S_RUN: begin
                add_a         = a_q[idx_q];
                add_b         = sub_q ? ~b_q[idx_q] : b_q[idx_q];
                add_cin       = carry_q;
                res_d[idx_q]  = add_s;
                carry_d       = add_cout;
                if (idx_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + {{(LW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign carry_out = carry_q;

    for (genvar g = 0; g < NW; g++) begin : g_result
        assign result[g*W +: W] = res_q[g];
    end

endmodule
`default_nettype wire

// File: doc/add_mp_ctrl.md
ADD_MP_CTRL -- requirements
Module: add_mp_ctrl

Interface
REQ-001 Parameter W, default 64, word width; SHALL equal the shared adder64 width.
REQ-002 Parameter NW, default 4, maximum operand length in words (operand width NW*W = 256).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 len  input  2  operand length minus one (0..3 → 1..4 words); sampled with start.
REQ-008 op_a  input  NW*W  operand A, word 0 = bits [W-1:0]; sampled with start.
REQ-009 op_b  input  NW*W  operand B; sampled with start.
REQ-010 busy  output  1  high while not in IDLE.
REQ-011 done  output  1  one-cycle pulse, result/carry_out valid.
REQ-012 result  output  NW*W  registered result; words above len SHALL read 0.
REQ-013 carry_out  output  1  final carry (sub: 1 = no borrow).
REQ-014 add_a  output  W  to adder64 input a.
REQ-015 add_b  output  W  to adder64 input b.
REQ-016 add_cin  output  1  to adder64 input cin.
REQ-017 add_s  input  W  from adder64 sum s (combinational, same cycle).
REQ-018 add_cout  input  1  from adder64 carry out.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; IDLE→RUN on start; RUN→DONE when idx==len_r at edge; DONE→IDLE unconditionally.
REQ-020 On start in IDLE: capture op_a, op_b, sub, len into a_r, b_r, sub_r, len_r; idx=0; carry_r=sub; result cleared to 0.
REQ-021 In RUN: add_a = a_r word idx; add_b = b_r word idx, bitwise inverted when sub_r=1; add_cin = carry_r.
REQ-022 At each RUN edge: result word idx ← add_s; carry_r ← add_cout; idx ← idx+1 unless idx==len_r.
REQ-023 Outside RUN, add_a, add_b, add_cin SHALL be driven 0.
REQ-024 done SHALL be high exactly during DONE; carry_out SHALL equal carry_r, held until next start.
REQ-025 result and carry_out SHALL hold their values in IDLE until the next accepted start.
REQ-026 Latency: start sampled at edge T → done high in cycle T+len+2 (edges after T); 1-word op: done 2 cycles after start edge.
REQ-027 start while busy (RUN or DONE) SHALL be ignored, no state change, no capture.
REQ-028 start held high continuously SHALL begin a new operation on the first edge back in IDLE (one idle cycle between ops).
REQ-029 Changes on op_a/op_b/sub/len after capture SHALL NOT affect the running operation.
REQ-030 idx SHALL never exceed len_r; no wrap beyond NW-1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, idx=0, carry_r=0, busy=0, done=0, result=0, carry_out=0, add_* =0.
REQ-032 Reset mid-RUN SHALL abort the operation with no done pulse; first start after rst_n release SHALL be accepted normally.

Verification
REQ-033 len=0, sub=0, A=0x0000ffff0000ffff, B=0xffff0000ffff0000 → result=0x…0000_ffffffffffffffff, carry_out=0, done 2 cycles after start.
REQ-034 len=1, sub=0, A word0=0xffffffffffffffff, A word1=0x1, B word0=0x1, B word1=0x2 → word0=0, word1=0x4, carry_out=0, done 3 cycles after start.
REQ-035 len=3, sub=0, A=all ones (256b), B=1 → result=0, carry_out=1, done 5 cycles after start, busy high 4 cycles before done plus done cycle.
REQ-036 len=0, sub=1, A=5, B=7 → word0=0xfffffffffffffffe, carry_out=0 (borrow); A=7, B=5 → word0=2, carry_out=1.
REQ-037 Assert start with new operands during RUN → ignored, original result unchanged; assert rst_n=0 during RUN idx=1 → busy/done/result 0 at once, no done pulse.
REQ-038 Bench SHALL compare every done result against a 257-bit reference model over ≥1000 random len/sub/operand sets.
